shift_seq_control: RTL and testbench
====================================

Name: shift_seq_control

Overview:
Parametrised sequencer for the logic-processor datapath. Gates register loads while idle and issues a programmable burst of Shift_En cycles per Execute press, then waits for Execute to be released. It replaces the fixed 8-shift controller so register files of any width reuse one control block. It adds shift-count selection, abort, progress index and done/busy status.

Parameters:
WIDTH, 8, maximum shifts per operation (datapath register width); legal range 1 or more.
CW, $clog2(WIDTH+1), width of ShiftCount and the internal remaining-count register.

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
LoadA  input  1  request to load register A (honoured only in IDLE)
LoadB  input  1  request to load register B (honoured only in IDLE)
Execute  input  1  level start request; must be released before the next operation
ShiftCount  input  CW  requested number of shifts, sampled on the start edge
Abort  input  1  terminates a RUN early
Step  input  1  single-step advance pulse (used only with the optional feature)
Shift_En  output  1  datapath shift enable
Ld_A  output  1  load enable for A
Ld_B  output  1  load enable for B
Busy  output  1  high in RUN
Done  output  1  high in HOLD after a normal completion
ShiftIdx  output  CW  0-based index of the shift issued this cycle; 0 outside RUN

Behaviour:
- Reset: on any edge with Reset=1 the block goes to IDLE and clears remaining, the abort flag and the index. It then reads Shift_En=0, Busy=0, Done=0, ShiftIdx=0, Ld_A=LoadA, Ld_B=LoadB. Reset mid-RUN truncates immediately, with no further Shift_En after that edge.
- States: IDLE, RUN, HOLD.
- IDLE:
  - Ld_A=LoadA and Ld_B=LoadB (combinational); Shift_En=0.
  - On an edge with Execute=1, latch N_eff = min(ShiftCount, WIDTH).
  - N_eff>0: go to RUN with remaining=N_eff.
  - N_eff=0: go straight to HOLD with Done=1. No Shift_En is issued.
- RUN:
  - Shift_En=1 and Busy=1; Ld_A=Ld_B=0 regardless of LoadA/LoadB.
  - ShiftIdx = N_eff - remaining.
  - Each edge decrements remaining; on the edge where remaining==1, go to HOLD.
  - Shift_En is therefore high for exactly N_eff consecutive cycles. Latency is one cycle from the Execute sample edge to the first Shift_En.
  - Abort=1 on an edge in RUN: go to HOLD with the abort flag set. The shift shown in that cycle counts as issued; no further shifts. Abort and final-count on the same edge behave as an abort (Done=0).
- HOLD:
  - All enables 0; Done = ~abort flag.
  - Go to IDLE on the first edge with Execute=0.
  - Holding Execute high never retriggers.
- Inputs are level-sampled; Abort outside RUN is ignored. ShiftCount changes after the start edge have no effect.
- Unique case on state, with a default that recovers to IDLE.

Optional Feature:
Macro SHIFT_SEQ_STEP_EN.
- Defined: in RUN, Shift_En = Step. remaining decrements only on edges with Step=1, so N_eff shifts are spread over N_eff Step pulses. Busy stays high while waiting. Abort still works with Step=0.
- Undefined: Step is ignored and behaviour is as above.

Decomposition:
- Package shift_seq_pkg holds the state typedef (enum logic [1:0] {IDLE, RUN, HOLD}) and a clamp function min_count(req, WIDTH).
- One sub-module, shift_down_counter (CW bits): load, decrement-enable, zero/one flags. The FSM and output decode stay in the top module.

Test Plan:
- WIDTH=8, ShiftCount=8, Execute held 12 cycles -> Shift_En high exactly cycles 1-8, ShiftIdx 0..7, then Done=1 until Execute drops, then IDLE.
- WIDTH=16, ShiftCount=20 -> clamps to 16 shifts. ShiftCount=0 -> no Shift_En, Done=1 in HOLD.
- ShiftCount=8, Abort pulsed during ShiftIdx=3 -> 4 shifts total, HOLD with Done=0.
- LoadA=LoadB=1 throughout a run -> Ld_A/Ld_B high only in IDLE, 0 in RUN and HOLD.
- Reset asserted during ShiftIdx=5 -> Shift_En=0 from the next cycle. Outputs at reset values; a new Execute starts a fresh count from ShiftIdx=0.
- With SHIFT_SEQ_STEP_EN, ShiftCount=3, Step pulsed every 4th cycle -> exactly 3 single-cycle Shift_En pulses aligned with Step, Busy high throughout, then Done.

Source files
------------

// File: rtl/shift_seq_control_pkg.sv
// Shared types and helpers for the shift sequencer.
// The state encoding lives here so the top and any debug tooling agree on it.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Clamp a requested shift count to the datapath width.
    function automatic int unsigned min_count(input int unsigned req, input int unsigned width);
        return (req < width) ? req : width;
    endfunction

endpackage

// File: rtl/shift_seq_control_counter.sv
// Down-counter holding the number of shifts still to issue.
// Load wins over decrement; the count never wraps below zero.
module shift_down_counter #(
    parameter int CW = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_zero,
    output logic          o_one
);

    logic [CW-1:0] r_count;

    // Remaining-shift register: load on start, step down on each issued shift.
    always_ff @(posedge Clk) begin
        if (Reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec && (r_count != '0))
            r_count <= r_count - CW'(1);
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
    assign o_one   = (r_count == CW'(1));

endmodule

// File: rtl/shift_seq_control.sv
// Shift sequencer: gates register loads while idle, issues a burst of
// Shift_En cycles per Execute press, then waits for Execute release.
// Optional macro SHIFT_SEQ_STEP_EN: shifts advance only on Step pulses.
module shift_seq_control
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          LoadA,
    input  logic          LoadB,
    input  logic          Execute,
    input  logic [CW-1:0] ShiftCount,
    input  logic          Abort,
    input  logic          Step,
    output logic          Shift_En,
    output logic          Ld_A,
    output logic          Ld_B,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] ShiftIdx
);

    state_t        r_state;
    logic          r_abort;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_neff;

    logic [CW-1:0] w_neff_req;
    logic [CW-1:0] w_remaining;
    logic          w_zero;
    logic          w_one;
    logic          w_adv;
    logic          w_load;
    logic          w_dec;

    assign w_neff_req = CW'(min_count(32'(ShiftCount), WIDTH));

`ifdef SHIFT_SEQ_STEP_EN
    assign w_adv = Step;
`else
    // Step has no function in the free-running build.
    logic w_unused_step;
    assign w_unused_step = Step;
    assign w_adv = 1'b1;
`endif

    assign w_load = (r_state == IDLE) && Execute && (w_neff_req != '0);
    assign w_dec  = (r_state == RUN) && w_adv && !Abort;

    shift_down_counter #(.CW(CW)) u_remaining (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_load     (w_load),
        .i_load_val (w_neff_req),
        .i_dec      (w_dec),
        .o_count    (w_remaining),
        .o_zero     (w_zero),
        .o_one      (w_one)
    );

    // Control FSM; Busy/Done are registered alongside the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_abort <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neff  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (Execute) begin
                        r_neff  <= w_neff_req;
                        r_abort <= 1'b0;
                        if (w_neff_req != '0) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            // Zero-length request completes without shifting.
                            r_state <= HOLD;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Abort takes precedence over a simultaneous final count.
                    if (Abort) begin
                        r_state <= HOLD;
                        r_abort <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (w_adv && w_one) begin
                        r_state <= HOLD;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!Execute) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_abort <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Shift_En = r_busy & w_adv;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Ld_A     = LoadA & (r_state == IDLE);
    assign Ld_B     = LoadB & (r_state == IDLE);
    // Remaining is never zero while busy; the guard keeps a stale count from leaking.
    assign ShiftIdx = (r_busy && !w_zero) ? (r_neff - w_remaining) : '0;

endmodule

// File: tb/tb_shift_seq_control.sv
// Bench for shift_seq_control (WIDTH=8): table vectors, directed corner
// sequences, and random stimulus against an operation-level reference model.
module tb_shift_seq_control;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic          Clk = 1'b0;
    logic          Reset, LoadA, LoadB, Execute, Abort, Step;
    logic [CW-1:0] ShiftCount;
    logic          Shift_En, Ld_A, Ld_B, Busy, Done;
    logic [CW-1:0] ShiftIdx;

    shift_seq_control #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Reset(Reset), .LoadA(LoadA), .LoadB(LoadB),
        .Execute(Execute), .ShiftCount(ShiftCount), .Abort(Abort), .Step(Step),
        .Shift_En(Shift_En), .Ld_A(Ld_A), .Ld_B(Ld_B), .Busy(Busy),
        .Done(Done), .ShiftIdx(ShiftIdx)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    int sh_count = 0;

    // Operation-level model: is an operation in progress, how many shifts
    // it wants, how many have been issued, and whether it has ended.
    bit m_act = 0, m_fin = 0, m_ab = 0;
    int m_n = 0, m_shots = 0;

    typedef struct {
        logic          rst, la, lb, ex, ab;
        logic [CW-1:0] cnt;
        logic          e_sh, e_la, e_lb, e_busy, e_done;
        int            e_idx;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, clock, advance the model.
    task automatic cyc(input logic rst, la, lb, ex, input logic [CW-1:0] cnt,
                       input logic ab, st, input string tag,
                       output logic o_sh, o_la, o_lb, o_busy, o_done,
                       output logic [CW-1:0] o_idx);
        bit running, adv, e_sh;
        Reset = rst; LoadA = la; LoadB = lb; Execute = ex;
        ShiftCount = cnt; Abort = ab; Step = st;
        #1;
        running = m_act && !m_fin;
`ifdef SHIFT_SEQ_STEP_EN
        adv = st;
`else
        adv = 1'b1;
`endif
        e_sh = running && adv;
        o_sh = Shift_En; o_la = Ld_A; o_lb = Ld_B; o_busy = Busy; o_done = Done; o_idx = ShiftIdx;
        chk({tag, " Shift_En"}, 32'(Shift_En), 32'(e_sh));
        chk({tag, " Ld_A"},     32'(Ld_A),     32'(la && !m_act));
        chk({tag, " Ld_B"},     32'(Ld_B),     32'(lb && !m_act));
        chk({tag, " Busy"},     32'(Busy),     32'(running));
        chk({tag, " Done"},     32'(Done),     32'(m_act && m_fin && !m_ab));
        chk({tag, " ShiftIdx"}, 32'(ShiftIdx), running ? 32'(m_shots) : 32'd0);
        if (Shift_En === 1'b1) sh_count++;
        @(posedge Clk);
        if (rst) begin
            m_act = 0;
        end else if (!m_act) begin
            if (ex) begin
                m_act = 1; m_ab = 0; m_shots = 0;
                m_n   = (int'(cnt) > WIDTH) ? WIDTH : int'(cnt);
                m_fin = (m_n == 0);
            end
        end else if (!m_fin) begin
            if (ab) begin
                m_fin = 1; m_ab = 1;
            end else if (adv) begin
                m_shots++;
                if (m_shots == m_n) m_fin = 1;
            end
        end else if (!ex) begin
            m_act = 0;
        end
        @(negedge Clk);
    endtask

    task automatic add(input logic rst, la, lb, ex, input logic [CW-1:0] cnt, input logic ab,
                       input logic sh, ela, elb, busy, done, input int idx);
        vec_t v;
        v.rst = rst; v.la = la; v.lb = lb; v.ex = ex; v.cnt = cnt; v.ab = ab;
        v.e_sh = sh; v.e_la = ela; v.e_lb = elb; v.e_busy = busy; v.e_done = done; v.e_idx = idx;
        tbl.push_back(v);
    endtask

    logic s_sh, s_la, s_lb, s_busy, s_done;
    logic [CW-1:0] s_idx;

    initial begin
        Reset = 1; LoadA = 0; LoadB = 0; Execute = 0; ShiftCount = '0; Abort = 0; Step = 1;
        @(negedge Clk); @(negedge Clk);

        // ---- table: reset row, full 8-shift run with loads held, zero-count run
        add(1, 1, 0, 0, 4'd0, 0,  0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 4'd8, 0,  0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 1, 1, 4'd2, 0,  1, 0, 0, 1, 0, i);  // ShiftCount change mid-run ignored
        for (int i = 0; i < 3; i++)
            add(0, 1, 1, 1, 4'd8, 0,  0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 4'd8, 0,  0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 4'd8, 0,  0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 4'd0, 0,  0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 4'd0, 1,  0, 0, 0, 0, 1, 0);      // Abort outside RUN ignored
        add(0, 0, 1, 0, 4'd0, 0,  0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 4'd0, 0,  0, 0, 1, 0, 0, 0);
        foreach (tbl[k]) begin
            cyc(tbl[k].rst, tbl[k].la, tbl[k].lb, tbl[k].ex, tbl[k].cnt, tbl[k].ab, 1'b1,
                $sformatf("tbl%0d", k), s_sh, s_la, s_lb, s_busy, s_done, s_idx);
            chk($sformatf("tbl%0d vec Shift_En", k), 32'(s_sh),   32'(tbl[k].e_sh));
            chk($sformatf("tbl%0d vec Ld_A", k),     32'(s_la),   32'(tbl[k].e_la));
            chk($sformatf("tbl%0d vec Ld_B", k),     32'(s_lb),   32'(tbl[k].e_lb));
            chk($sformatf("tbl%0d vec Busy", k),     32'(s_busy), 32'(tbl[k].e_busy));
            chk($sformatf("tbl%0d vec Done", k),     32'(s_done), 32'(tbl[k].e_done));
            chk($sformatf("tbl%0d vec ShiftIdx", k), 32'(s_idx),  32'(tbl[k].e_idx));
        end

        // ---- clamp: ShiftCount=15 yields WIDTH shifts
        sh_count = 0;
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 4'd15, 0, 1, "clamp", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        chk("clamp shifts", 32'(sh_count), 32'd8);
        chk("clamp done", 32'(s_done), 32'd1);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 4'd0, 0, 1, "clamp_rel", s_sh, s_la, s_lb, s_busy, s_done, s_idx);

        // ---- abort during ShiftIdx=3: four shifts, Done=0
        sh_count = 0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 4'd8, 0, 1, "abort", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        cyc(0, 0, 0, 1, 4'd8, 1, 1, "abort_at", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        chk("abort idx", 32'(s_idx), 32'd3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 4'd8, 0, 1, "abort_hold", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        chk("abort shifts", 32'(sh_count), 32'd4);
        chk("abort done", 32'(s_done), 32'd0);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 4'd0, 0, 1, "abort_rel", s_sh, s_la, s_lb, s_busy, s_done, s_idx);

        // ---- reset during ShiftIdx=5, then a fresh run starts from 0
        sh_count = 0;
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 4'd8, 0, 1, "rstmid", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        cyc(1, 0, 0, 1, 4'd8, 0, 1, "rstmid_at", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        chk("rstmid idx", 32'(s_idx), 32'd5);
        cyc(0, 1, 1, 0, 4'd8, 0, 1, "rstmid_after", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        chk("rstmid shift_en", 32'(s_sh), 32'd0);
        chk("rstmid ld_a", 32'(s_la), 32'd1);
        chk("rstmid shifts", 32'(sh_count), 32'd6);
        cyc(0, 0, 0, 1, 4'd3, 0, 1, "rstmid_new", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        cyc(0, 0, 0, 1, 4'd3, 0, 1, "rstmid_new1", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        chk("rstmid restart idx", 32'(s_idx), 32'd0);
        chk("rstmid restart sh", 32'(s_sh), 32'd1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 4'd0, 0, 1, "rstmid_rel", s_sh, s_la, s_lb, s_busy, s_done, s_idx);

`ifdef SHIFT_SEQ_STEP_EN
        // ---- step mode: Step every 4th cycle spreads 3 shifts
        sh_count = 0;
        cyc(0, 0, 0, 1, 4'd3, 0, 0, "step_start", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        for (int i = 0; i < 12; i++)
            cyc(0, 0, 0, 1, 4'd3, 0, (i % 4 == 3), "step", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        chk("step shifts", 32'(sh_count), 32'd3);
        cyc(0, 0, 0, 1, 4'd3, 0, 0, "step_hold", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
        chk("step done", 32'(s_done), 32'd1);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 4'd0, 0, 0, "step_rel", s_sh, s_la, s_lb, s_busy, s_done, s_idx);
`endif

        // ---- random stimulus against the model
        begin
            logic ex = 0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 9) == 0) ex = ~ex;
                cyc(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), ex,
                    CW'($urandom_range(0, 15)), ($urandom_range(0, 11) == 0), 1'($urandom),
                    $sformatf("rnd%0d", i), s_sh, s_la, s_lb, s_busy, s_done, s_idx);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
